// File: rtl/cam_pixel_packer.sv
// Packs an RGB565 pixel stream into 128-bit words (8 pixels per word) and
// streams them out through a first-word-fall-through FIFO.
// Malformed frames and overflows end with a zero TLAST flush word.
module cam_pixel_packer #(
    parameter int H_PIXELS   = 640,
    parameter int V_LINES    = 360,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          pixel_valid_in,
    input  logic [15:0]                   pixel_data_in,
    input  logic                          pixel_sof_in,
    output logic [127:0]                  m_axis_data,
    output logic                          m_axis_tlast,
    output logic                          m_axis_valid,
    input  logic                          m_axis_ready,
    output logic                          frame_done_out,
    output logic                          frame_drop_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

    localparam int WORDS_PER_FRAME = H_PIXELS * V_LINES / 8;
    localparam int AW              = $clog2(FIFO_DEPTH);
    localparam int CNT_W           = AW + 1;
    localparam logic [11:0]      LAST_WORD = 12'(WORDS_PER_FRAME - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

    // Reset asserts asynchronously but is released in step with clk_in.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples its inputs as they were before the edge.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_rst_sync <= 2'b00;
        else           r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_pix_idx, w_pix_idx_nxt;
    logic [11:0]      r_word_idx, w_word_idx_nxt;
    logic [111:0]     r_shift, w_shift_nxt;
    logic             r_done, w_done_nxt;
    logic             r_drop, w_drop_nxt;

    logic [128:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full, w_empty, w_push, w_pop;
    logic [128:0]     w_push_word;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && m_axis_ready;

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_pix_idx_nxt  = r_pix_idx;
        w_word_idx_nxt = r_word_idx;
        w_shift_nxt    = r_shift;
        w_push         = 1'b0;
        w_push_word    = {1'b0, pixel_data_in, r_shift};
        w_done_nxt     = 1'b0;
        w_drop_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (pixel_valid_in && pixel_sof_in) begin
                    w_shift_nxt    = {pixel_data_in, r_shift[111:16]};
                    w_pix_idx_nxt  = 3'd1;
                    w_word_idx_nxt = 12'd0;
                    w_state_nxt    = PACK;
                end
            end
            PACK: begin
                if (pixel_valid_in) begin
                    if (pixel_sof_in && (r_pix_idx != 3'd0 || r_word_idx != 12'd0)) begin
                        w_drop_nxt  = 1'b1;
                        w_state_nxt = FLUSH;
                    end else if (r_pix_idx == 3'd7) begin
                        // Full is judged on the registered count; a same-cycle pop does not help.
                        if (w_full) begin
                            w_drop_nxt  = 1'b1;
                            w_state_nxt = FLUSH;
                        end else begin
                            w_push           = 1'b1;
                            w_push_word[128] = (r_word_idx == LAST_WORD);
                            w_pix_idx_nxt    = 3'd0;
                            if (r_word_idx == LAST_WORD) begin
                                w_done_nxt  = 1'b1;
                                w_state_nxt = IDLE;
                            end else begin
                                w_word_idx_nxt = r_word_idx + 12'd1;
                            end
                        end
                    end else begin
                        w_shift_nxt   = {pixel_data_in, r_shift[111:16]};
                        w_pix_idx_nxt = r_pix_idx + 3'd1;
                    end
                end
            end
            FLUSH: begin
                if (!w_full) begin
                    w_push      = 1'b1;
                    w_push_word = {1'b1, 128'd0};
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= IDLE;
            r_pix_idx  <= 3'd0;
            r_word_idx <= 12'd0;
            r_shift    <= '0;
            r_done     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pix_idx  <= w_pix_idx_nxt;
            r_word_idx <= w_word_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_done     <= w_done_nxt;
            r_drop     <= w_drop_nxt;
        end
    end

    // NOTE: the storage array has no reset; outputs are gated by the empty
    // flag so stale entries are never visible.
    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_word;
    end

    always_ff @(posedge clk_in or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign m_axis_valid   = !w_empty;
    assign m_axis_data    = w_empty ? 128'd0 : r_mem[r_rd_ptr][127:0];
    assign m_axis_tlast   = w_empty ? 1'b0   : r_mem[r_rd_ptr][128];
    assign frame_done_out = r_done;
    assign frame_drop_out = r_drop;
    assign fifo_count_out = r_count;

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Directed bench for cam_pixel_packer using a reduced 64x4 frame (32 words)
// so every scenario, including FIFO overflow, completes quickly.
module tb_cam_pixel_packer;

    localparam int H         = 64;
    localparam int V         = 4;
    localparam int DEPTH     = 16;
    localparam int WPF       = H * V / 8;
    localparam int FRAME_PIX = H * V;

    logic         clk_in         = 1'b0;
    logic         rst_n_in       = 1'b1;
    logic         pixel_valid_in = 1'b0;
    logic [15:0]  pixel_data_in  = 16'd0;
    logic         pixel_sof_in   = 1'b0;
    logic         m_axis_ready   = 1'b0;
    logic [127:0] m_axis_data;
    logic         m_axis_tlast;
    logic         m_axis_valid;
    logic         frame_done_out;
    logic         frame_drop_out;
    logic [4:0]   fifo_count_out;

    cam_pixel_packer #(.H_PIXELS(H), .V_LINES(V), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .pixel_valid_in (pixel_valid_in),
        .pixel_data_in  (pixel_data_in),
        .pixel_sof_in   (pixel_sof_in),
        .m_axis_data    (m_axis_data),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_valid   (m_axis_valid),
        .m_axis_ready   (m_axis_ready),
        .frame_done_out (frame_done_out),
        .frame_drop_out (frame_drop_out),
        .fifo_count_out (fifo_count_out)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0, drop_cnt = 0, both_cnt = 0;
    int ready_mode = 0;  // 0 = held low, 1 = held high, 2 = random
    logic [128:0] got_q[$];
    logic [128:0] exp_q[$];

    // Inputs change just after posedge, so at negedge the handshake for the
    // coming edge is already settled.
    always @(negedge clk_in) begin
        if (m_axis_valid && m_axis_ready) got_q.push_back({m_axis_tlast, m_axis_data});
        if (frame_done_out) done_cnt++;
        if (frame_drop_out) drop_cnt++;
        if (frame_done_out && frame_drop_out) both_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d words", got_q.size());
        $fatal(1);
    end

    task automatic cycle(input logic v, input logic sof, input logic [15:0] d);
        pixel_valid_in = v;
        pixel_sof_in   = sof;
        pixel_data_in  = d;
        case (ready_mode)
            0:       m_axis_ready = 1'b0;
            1:       m_axis_ready = 1'b1;
            default: m_axis_ready = 1'($urandom_range(0, 1));
        endcase
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_pixels(input logic [15:0] base, input int n, input logic first_sof,
                               input int gap);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, first_sof && (i == 0), base + 16'(i));
            repeat (gap) cycle(1'b0, 1'b0, 16'd0);
        end
    endtask

    function automatic logic [128:0] make_word(input logic [15:0] base, input int w,
                                               input logic last);
        logic [127:0] d;
        for (int k = 0; k < 8; k++) d[16*k +: 16] = base + 16'(8 * w + k);
        return {last, d};
    endfunction

    task automatic add_frame(input logic [15:0] base, input int nwords, input logic complete);
        for (int w = 0; w < nwords; w++)
            exp_q.push_back(make_word(base, w, complete && (w == WPF - 1)));
    endtask

    task automatic add_flush();
        exp_q.push_back({1'b1, 128'd0});
    endtask

    function automatic int first_diff();
        int n;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic drain();
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        ready_mode = 1;
        while (quiet < 4 && n < 2000) begin
            cycle(1'b0, 1'b0, 16'd0);
            n++;
            quiet = (!m_axis_valid && fifo_count_out == 5'd0) ? quiet + 1 : 0;
        end
        total++;
        if (quiet < 4) begin
            bad++;
            $display("FAIL drain: fifo_count=%0d after %0d cycles, required 0", fifo_count_out, n);
        end
    endtask

    task automatic test_reset();
        ready_mode = 0;
        #2 rst_n_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        total++; if (m_axis_valid !== 1'b0)   begin bad++; $display("FAIL reset valid: got %b required 0", m_axis_valid); end
        total++; if (m_axis_tlast !== 1'b0)   begin bad++; $display("FAIL reset tlast: got %b required 0", m_axis_tlast); end
        total++; if (m_axis_data !== 128'd0)  begin bad++; $display("FAIL reset data: got %h required 0", m_axis_data); end
        total++; if (fifo_count_out !== 5'd0) begin bad++; $display("FAIL reset count: got %0d required 0", fifo_count_out); end
        total++; if (frame_done_out !== 1'b0 || frame_drop_out !== 1'b0) begin
            bad++; $display("FAIL reset pulses: got done=%b drop=%b required 0 0", frame_done_out, frame_drop_out);
        end
        rst_n_in = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 16'd0);
    endtask

    task automatic clean_frame_with_latency(input string name);
        logic [127:0] word0;
        word0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
        ready_mode = 1;
        for (int n = 0; n < FRAME_PIX; n++) begin
            cycle(1'b1, n == 0, 16'(n));
            if (n == 6) begin
                total++;
                if (m_axis_valid !== 1'b0) begin bad++; $display("FAIL %s valid after 7 pixels: got %b required 0", name, m_axis_valid); end
            end
            if (n == 7) begin
                total++;
                if (m_axis_valid !== 1'b1 || m_axis_data !== word0 || m_axis_tlast !== 1'b0) begin
                    bad++;
                    $display("FAIL %s word0 latency: got valid=%b data=%h tlast=%b required 1 %h 0",
                             name, m_axis_valid, m_axis_data, m_axis_tlast, word0);
                end
            end
        end
    endtask

    task automatic test_clean_frame();
        int d0, r0, idx;
        got_q.delete(); exp_q.delete();
        d0 = done_cnt; r0 = drop_cnt;
        add_frame(16'h0000, WPF, 1'b1);
        clean_frame_with_latency("clean");
        drain();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL clean words: got %0d required %0d", got_q.size(), exp_q.size()); end
        idx = first_diff();
        total++; if (idx >= 0) begin bad++; $display("FAIL clean word %0d: got %h required %h", idx, got_q[idx], exp_q[idx]); end
        total++; if (done_cnt - d0 != 1 || drop_cnt - r0 != 0) begin
            bad++; $display("FAIL clean pulses: got done=%0d drop=%0d required 1 0", done_cnt - d0, drop_cnt - r0);
        end
    endtask

    task automatic test_sparse_backpressure();
        int d0, r0, idx;
        got_q.delete(); exp_q.delete();
        d0 = done_cnt; r0 = drop_cnt;
        add_frame(16'h1000, WPF, 1'b1);
        add_frame(16'h2000, WPF, 1'b1);
        ready_mode = 2;
        send_pixels(16'h1000, FRAME_PIX, 1'b1, 2);
        send_pixels(16'h2000, FRAME_PIX, 1'b1, 2);
        drain();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL sparse words: got %0d required %0d", got_q.size(), exp_q.size()); end
        idx = first_diff();
        total++; if (idx >= 0) begin bad++; $display("FAIL sparse word %0d: got %h required %h", idx, got_q[idx], exp_q[idx]); end
        total++; if (done_cnt - d0 != 2 || drop_cnt - r0 != 0) begin
            bad++; $display("FAIL sparse pulses: got done=%0d drop=%0d required 2 0", done_cnt - d0, drop_cnt - r0);
        end
    endtask

    task automatic test_overflow();
        int d0, r0, idx;
        got_q.delete(); exp_q.delete();
        d0 = done_cnt; r0 = drop_cnt;
        ready_mode = 0;
        send_pixels(16'h3000, FRAME_PIX, 1'b1, 0);
        total++; if (fifo_count_out !== 5'd16) begin bad++; $display("FAIL overflow count: got %0d required 16", fifo_count_out); end
        total++; if (drop_cnt - r0 != 1) begin bad++; $display("FAIL overflow drop: got %0d required 1", drop_cnt - r0); end
        add_frame(16'h3000, DEPTH, 1'b0);
        add_flush();
        drain();
        add_frame(16'h4000, WPF, 1'b1);
        send_pixels(16'h4000, FRAME_PIX, 1'b1, 0);
        drain();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL overflow words: got %0d required %0d", got_q.size(), exp_q.size()); end
        idx = first_diff();
        total++; if (idx >= 0) begin bad++; $display("FAIL overflow word %0d: got %h required %h", idx, got_q[idx], exp_q[idx]); end
        total++; if (done_cnt - d0 != 1 || drop_cnt - r0 != 1) begin
            bad++; $display("FAIL overflow pulses: got done=%0d drop=%0d required 1 1", done_cnt - d0, drop_cnt - r0);
        end
    endtask

    task automatic test_early_sof();
        int d0, r0, idx;
        got_q.delete(); exp_q.delete();
        d0 = done_cnt; r0 = drop_cnt;
        ready_mode = 1;
        send_pixels(16'h5000, 80, 1'b1, 0);
        cycle(1'b1, 1'b1, 16'h6000);
        total++; if (frame_drop_out !== 1'b1) begin bad++; $display("FAIL early_sof drop pulse: got %b required 1", frame_drop_out); end
        send_pixels(16'h6001, 30, 1'b0, 0);
        send_pixels(16'h7000, FRAME_PIX, 1'b1, 0);
        drain();
        add_frame(16'h5000, 10, 1'b0);
        add_flush();
        add_frame(16'h7000, WPF, 1'b1);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL early_sof words: got %0d required %0d", got_q.size(), exp_q.size()); end
        idx = first_diff();
        total++; if (idx >= 0) begin bad++; $display("FAIL early_sof word %0d: got %h required %h", idx, got_q[idx], exp_q[idx]); end
        total++; if (done_cnt - d0 != 1 || drop_cnt - r0 != 1) begin
            bad++; $display("FAIL early_sof pulses: got done=%0d drop=%0d required 1 1", done_cnt - d0, drop_cnt - r0);
        end
    endtask

    task automatic test_junk_trailing();
        int d0, r0, idx;
        got_q.delete(); exp_q.delete();
        d0 = done_cnt; r0 = drop_cnt;
        ready_mode = 1;
        send_pixels(16'h8000, 50, 1'b0, 0);
        send_pixels(16'h9000, FRAME_PIX, 1'b1, 0);
        send_pixels(16'hA000, 40, 1'b0, 0);
        drain();
        add_frame(16'h9000, WPF, 1'b1);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL junk words: got %0d required %0d", got_q.size(), exp_q.size()); end
        idx = first_diff();
        total++; if (idx >= 0) begin bad++; $display("FAIL junk word %0d: got %h required %h", idx, got_q[idx], exp_q[idx]); end
        total++; if (done_cnt - d0 != 1 || drop_cnt - r0 != 0) begin
            bad++; $display("FAIL junk pulses: got done=%0d drop=%0d required 1 0", done_cnt - d0, drop_cnt - r0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0, idx;
        got_q.delete(); exp_q.delete();
        ready_mode = 0;
        send_pixels(16'hB000, 40, 1'b1, 0);
        total++; if (fifo_count_out !== 5'd5) begin bad++; $display("FAIL midreset buffered: got %0d required 5", fifo_count_out); end
        #2 rst_n_in = 1'b0;
        #1;
        total++; if (m_axis_valid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_data !== 128'd0) begin
            bad++; $display("FAIL midreset outputs: got valid=%b tlast=%b data=%h required 0 0 0", m_axis_valid, m_axis_tlast, m_axis_data);
        end
        total++; if (fifo_count_out !== 5'd0) begin bad++; $display("FAIL midreset count: got %0d required 0", fifo_count_out); end
        cycle(1'b0, 1'b0, 16'd0);
        rst_n_in = 1'b1;
        ready_mode = 1;
        repeat (3) cycle(1'b0, 1'b0, 16'd0);
        got_q.delete();
        d0 = done_cnt;
        add_frame(16'h0000, WPF, 1'b1);
        clean_frame_with_latency("midreset");
        drain();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL midreset words: got %0d required %0d", got_q.size(), exp_q.size()); end
        idx = first_diff();
        total++; if (idx >= 0) begin bad++; $display("FAIL midreset word %0d: got %h required %h", idx, got_q[idx], exp_q[idx]); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL midreset done: got %0d required 1", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_sparse_backpressure();
        test_overflow();
        test_early_sof();
        test_junk_trailing();
        test_reset_mid_frame();
        total++;
        if (both_cnt != 0) begin bad++; $display("FAIL pulse overlap: got %0d cycles with done and drop, required 0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
